// File: rtl/div_pkg.sv
// Shared types and constants for the 16-bit restoring divider.
// Signed operation is selected with DIV_16BIT_RESTORE_SIGNED_EN.
package div_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ITER_NUM   = DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(ITER_NUM);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ITER_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] div;
    logic                  sign_q;
    logic                  sign_r;
  } dp_t;

  // Two's complement negate when neg is set; 16'h8000 maps onto itself.
  function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_16bit_restore_step.sv
// One combinational radix-2 restoring step on unsigned magnitudes.
module div_16bit_restore_step
  import div_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] div,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic [DATA_WIDTH-1:0] quo_nxt
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // shifted < 2*div, so the 17-bit difference never overflows its sign bit
  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, div};

  always_comb begin
    rem_nxt = shifted[DATA_WIDTH-1:0];
    quo_nxt = {quo[DATA_WIDTH-2:0], 1'b0};
    if (!trial[DATA_WIDTH]) begin
      rem_nxt = trial[DATA_WIDTH-1:0];
      quo_nxt = {quo[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_16bit_restore.sv
// Iterative 16-bit restoring divider with valid/ready input and o_end pulse.
// Define DIV_16BIT_RESTORE_SIGNED_EN for two's complement operands/results.
module div_16bit_restore
  import div_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_err
);

  state_t                state, state_nxt;
  dp_t                   dp;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
  logic                  x_neg, y_neg;
  logic                  accept, y_zero;

`ifdef DIV_16BIT_RESTORE_SIGNED_EN
  assign x_neg = i_num_x[DATA_WIDTH-1];
  assign y_neg = i_num_y[DATA_WIDTH-1];
`else
  assign x_neg = 1'b0;
  assign y_neg = 1'b0;
`endif

  assign o_ready = (state == IDLE);
  assign o_end   = (state == DONE);
  assign accept  = i_valid && o_ready;
  assign y_zero  = (i_num_y == '0);

  div_16bit_restore_step u_step (
    .rem     (dp.rem),
    .quo     (dp.quo),
    .div     (dp.div),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = y_zero ? DONE : CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp    <= '0;
      cnt   <= '0;
      o_quo <= '0;
      o_rem <= '0;
      o_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (y_zero) begin
              o_quo <= '1;
              o_rem <= i_num_x;
              o_err <= 1'b1;
            end else begin
              dp.rem    <= '0;
              dp.quo    <= apply_sign(i_num_x, x_neg);
              dp.div    <= apply_sign(i_num_y, y_neg);
              dp.sign_q <= x_neg ^ y_neg;
              dp.sign_r <= x_neg;
            end
          end
        end
        CALC: begin
          dp.rem <= rem_nxt;
          dp.quo <= quo_nxt;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          // Sign flags are constant zero in the unsigned build, so this is a copy
          o_quo <= apply_sign(dp.quo, dp.sign_q);
          o_rem <= apply_sign(dp.rem, dp.sign_r);
          o_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16bit_restore.sv
// Scoreboard bench for div_16bit_restore against an arithmetic reference model.
module tb_div_16bit_restore;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_num_x = '0;
  logic [15:0] i_num_y = '0;
  logic        o_ready, o_end, o_err;
  logic [15:0] o_quo, o_rem;

  div_16bit_restore dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num_x (i_num_x),
    .i_num_y (i_num_y),
    .o_end   (o_end),
    .o_quo   (o_quo),
    .o_rem   (o_rem),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
    int          c0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer division; SV / truncates toward zero and % follows the dividend sign
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int c0);
    exp_t m;
    int sx, sy;
    m.c0 = c0;
    if (y == 16'h0000) begin
      m.q = 16'hFFFF; m.r = x; m.e = 1'b1; m.lat = 0;
    end else begin
`ifdef DIV_16BIT_RESTORE_SIGNED_EN
      sx = $signed(x);
      sy = $signed(y);
`else
      sx = int'(x);
      sy = int'(y);
`endif
      m.q = 16'(sx / sy);
      m.r = 16'(sx % sy);
      m.e = 1'b0;
      m.lat = 17;
    end
    return m;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n && o_end) begin
      if (sb.size() == 0) begin
        check("unexpected_end", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quo", o_quo, mon_e.q);
        check("rem", o_rem, mon_e.r);
        check("err", o_err, mon_e.e);
        check("latency", cyc - mon_e.c0, mon_e.lat);
      end
    end
  end

  // Issue one operation; operands are scrambled after the accept edge unless hold is set
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit hold,
                       output int c0, output int low_waits);
    bit rdy, ok;
    ok = 0;
    low_waits = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_num_x = x;
    i_num_y = y;
    for (int k = 0; k < 200; k++) begin
      rdy = o_ready;
      if (!rdy) low_waits++;
      @(posedge i_clk);
      if (rdy) begin ok = 1; break; end
      @(negedge i_clk);
    end
    #1;
    c0 = cyc;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else sb.push_back(model(x, y, c0));
    if (!hold) begin
      i_valid = 1'b0;
      i_num_x = 16'($urandom);
      i_num_y = 16'($urandom);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge i_clk);
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_end"},   o_end,   0);
    check({tag, "_quo"},   o_quo,   0);
    check({tag, "_rem"},   o_rem,   0);
    check({tag, "_err"},   o_err,   0);
  endtask

  int c0a, c0b, lw, lw2;
  logic [15:0] rx, ry;
  int sel;

  initial begin
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    do_op(16'hFFFA, 16'hFFF9, 0, c0a, lw);
    do_op(16'hFFFA, 16'h0005, 0, c0a, lw);
    do_op(16'h8000, 16'hFFFF, 0, c0a, lw);
    drain();

    // valid held high across two operations
    do_op(16'h0064, 16'h0007, 1, c0a, lw);
    do_op(16'h0064, 16'h0007, 0, c0b, lw2);
    check("second_accept_gap", c0b - c0a, 19);
    check("ready_low_cycles", lw2, 18);
    drain();

    do_op(16'h1234, 16'h0000, 0, c0a, lw);
    do_op(16'h0009, 16'h0003, 0, c0a, lw);
    drain();

    // reset during the 8th CALC cycle aborts the operation silently
    do_op(16'h00FF, 16'h0010, 0, c0a, lw);
    repeat (8) @(negedge i_clk);
    i_num_x = 16'hA5A5;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("abort");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (25) @(negedge i_clk);
    check_reset_outputs("after_abort");

    do_op(16'h00FF, 16'h0010, 0, c0a, lw);
    repeat (5) @(negedge i_clk);
    i_num_x = 16'h7777;
    i_num_y = 16'h0001;
    drain();

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      rx = 16'($urandom);
      if (sel == 9) rx = 16'h8000;
      if (sel == 0) ry = 16'h0000;
      else if (sel < 4) ry = 16'($urandom_range(1, 15));
      else if (sel == 9) ry = 16'hFFFF;
      else ry = 16'($urandom);
      do_op(rx, ry, n[0], c0a, lw);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
